// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: stall FSM state encoding, register-index width,
// NOP encoding and the per-stage pause bundle used by the stall controller.
package pipeline_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MULDIV   = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;

  // A paused stage register emits this word downstream as a bubble.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic pc;
    logic fi_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } pause_t;

  localparam pause_t PAUSE_NONE = '{pc: 1'b0, fi_id: 1'b0, id_ex: 1'b0, ex_mem: 1'b0, mem_wb: 1'b0};
  // Freeze everything up to EX_MEM; WB keeps draining and receives a bubble.
  localparam pause_t PAUSE_HOLD = '{pc: 1'b1, fi_id: 1'b1, id_ex: 1'b1, ex_mem: 1'b1, mem_wb: 1'b0};

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: purely combinational, shared with the forwarding unit.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_regwe,
  input  logic             ex_is_load,
  output logic             hz
);

  logic rs_match;
  logic rt_match;

  // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign rs_match = id_use_rs && (id_rs == ex_rd);
  assign rt_match = id_use_rt && (id_rt == ex_rd);
  assign hz       = ex_is_load && ex_regwe && (ex_rd != '0) && (rs_match || rt_match);

endmodule

// File: rtl/stall_ctrl.sv
// Central hazard/stall controller producing per-stage pause and PC hold.
// Optional performance counters are enabled with `define STALL_CTRL_PERF_EN.
module stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int MULDIV_LAT  = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_regwe,
  input  logic             ex_is_load,
  input  logic             ex_muldiv_start,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pause_pc,
  output logic             pause_fi_id,
  output logic             pause_id_ex,
  output logic             pause_ex_mem,
  output logic             pause_mem_wb,
  output logic             busy,
  output logic             mem_err
`ifdef STALL_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_lu,
  output logic [31:0]      perf_md,
  output logic [31:0]      perf_mw
`endif
);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             err_set;
  logic             hz;
  pause_t           pause;

  hazard_detect u_hazard_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .ex_rd      (ex_rd),
    .ex_regwe   (ex_regwe),
    .ex_is_load (ex_is_load),
    .hz         (hz)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    pause     = PAUSE_NONE;
    state_nxt = state;
    cnt_nxt   = cnt;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req) begin
          // A zero-wait access (ack in the same cycle) needs no stall at all.
          if (!mem_ack) begin
            pause     = PAUSE_HOLD;
            state_nxt = MEM_WAIT;
            cnt_nxt   = '0;
          end
        end else if (ex_muldiv_start) begin
          pause     = PAUSE_HOLD;
          state_nxt = MULDIV;
          cnt_nxt   = CNT_W'(MULDIV_LAT - 2);
        end else if (hz) begin
          // Front end holds one cycle while ID_EX captures a bubble behind the load.
          pause.pc    = 1'b1;
          pause.fi_id = 1'b1;
        end
      end
      MULDIV: begin
        if (cnt != '0) begin
          pause   = PAUSE_HOLD;
          cnt_nxt = cnt - 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_W'(MEM_TIMEOUT)) begin
          err_set   = 1'b1;
          state_nxt = IDLE;
        end else begin
          pause   = PAUSE_HOLD;
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset forces every stage register to emit NOPs regardless of the current state.
  assign pause_pc     = rst | pause.pc;
  assign pause_fi_id  = rst | pause.fi_id;
  assign pause_id_ex  = rst | pause.id_ex;
  assign pause_ex_mem = rst | pause.ex_mem;
  assign pause_mem_wb = rst | pause.mem_wb;
  assign busy         = !rst && (state != IDLE);

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      mem_err <= mem_err | err_set;
    end
  end

`ifdef STALL_CTRL_PERF_EN
  logic lu_stall, md_stall, mw_stall;

  // Attribute each paused cycle to its cause via the state it leads into.
  assign lu_stall = pause.pc && !pause.id_ex;
  assign md_stall = pause.ex_mem && (state_nxt == MULDIV);
  assign mw_stall = pause.ex_mem && (state_nxt == MEM_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lu <= '0;
      perf_md <= '0;
      perf_mw <= '0;
    end else begin
      if (lu_stall) perf_lu <= sat_inc(perf_lu);
      if (md_stall) perf_md <= sat_inc(perf_md);
      if (mw_stall) perf_mw <= sat_inc(perf_mw);
    end
  end
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed scenarios followed by random
// traffic, all checked against a cycle-level behavioural model of the stall rules.
module tb_stall_ctrl;

  localparam int LAT = 4;
  localparam int TO  = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_use_rs, id_use_rt, ex_regwe, ex_is_load;
  logic       ex_muldiv_start, mem_req, mem_ack;
  logic       pause_pc, pause_fi_id, pause_id_ex, pause_ex_mem, pause_mem_wb;
  logic       busy, mem_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: remaining mul/div occupancy cycles, memory-wait flag and elapsed
  // wait cycles, sticky error.
  int m_md_left  = 0;
  bit m_mem_wait = 1'b0;
  int m_elapsed  = 0;
  bit m_err      = 1'b0;

  always #5 clk = ~clk;

  stall_ctrl #(.MULDIV_LAT(LAT), .MEM_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .ex_rd           (ex_rd),
    .ex_regwe        (ex_regwe),
    .ex_is_load      (ex_is_load),
    .ex_muldiv_start (ex_muldiv_start),
    .mem_req         (mem_req),
    .mem_ack         (mem_ack),
    .pause_pc        (pause_pc),
    .pause_fi_id     (pause_fi_id),
    .pause_id_ex     (pause_id_ex),
    .pause_ex_mem    (pause_ex_mem),
    .pause_mem_wb    (pause_mem_wb),
    .busy            (busy),
    .mem_err         (mem_err)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_rd = 5'd0; ex_regwe = 1'b0; ex_is_load = 1'b0;
    ex_muldiv_start = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  // Inputs are already driven (posedge+1); sample mid-cycle, compare, then
  // advance the model across the next rising edge.
  task automatic tick(input string tag);
    bit hz, e_front, e_back, e_wb, e_busy;
    int n_md, n_el;
    bit n_mw, n_err;
    #3;
    hz = ex_is_load && ex_regwe && (ex_rd != 5'd0) &&
         ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    e_front = 1'b0; e_back = 1'b0; e_wb = 1'b0;
    n_md = m_md_left; n_mw = m_mem_wait; n_el = m_elapsed; n_err = m_err;
    e_busy = (m_md_left > 0) || m_mem_wait;
    if (rst) begin
      e_front = 1'b1; e_back = 1'b1; e_wb = 1'b1; e_busy = 1'b0;
      n_md = 0; n_mw = 1'b0; n_el = 0; n_err = 1'b0;
    end else if (m_md_left > 0) begin
      e_front = (m_md_left > 1); e_back = e_front;
      n_md = m_md_left - 1;
    end else if (m_mem_wait) begin
      if (mem_ack) n_mw = 1'b0;
      else if (m_elapsed == TO) begin n_mw = 1'b0; n_err = 1'b1; end
      else begin e_front = 1'b1; e_back = 1'b1; n_el = m_elapsed + 1; end
    end else if (mem_req) begin
      if (!mem_ack) begin e_front = 1'b1; e_back = 1'b1; n_mw = 1'b1; n_el = 0; end
    end else if (ex_muldiv_start) begin
      e_front = 1'b1; e_back = 1'b1; n_md = LAT - 1;
    end else if (hz) begin
      e_front = 1'b1;
    end
    check({tag, ".pause_pc"},     pause_pc,     e_front);
    check({tag, ".pause_fi_id"},  pause_fi_id,  e_front);
    check({tag, ".pause_id_ex"},  pause_id_ex,  e_back);
    check({tag, ".pause_ex_mem"}, pause_ex_mem, e_back);
    check({tag, ".pause_mem_wb"}, pause_mem_wb, e_wb);
    check({tag, ".busy"},         busy,         e_busy);
    check({tag, ".mem_err"},      mem_err,      m_err);
    @(posedge clk);
    m_md_left = n_md; m_mem_wait = n_mw; m_elapsed = n_el; m_err = n_err;
    cyc++;
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    tick("reset");
    rst = 1'b0;
    tick("post_reset");

    // Load-use: lw $3 in EX, add reading $3 in ID.
    ex_is_load = 1'b1; ex_regwe = 1'b1; ex_rd = 5'd3; id_use_rs = 1'b1; id_rs = 5'd3;
    tick("lu_hit");
    ex_is_load = 1'b0; ex_regwe = 1'b0; ex_rd = 5'd0;
    tick("lu_cleared");
    ex_is_load = 1'b1; ex_regwe = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
    tick("lu_rd0");
    ex_rd = 5'd3; id_rs = 5'd3; id_use_rs = 1'b0;
    tick("lu_no_use");
    id_use_rt = 1'b1; id_rt = 5'd3;
    tick("lu_rt_hit");
    idle_inputs();

    // Mul/div occupancy.
    ex_muldiv_start = 1'b1;
    tick("md_issue");
    ex_muldiv_start = 1'b0;
    for (int i = 0; i < LAT - 1; i++) tick($sformatf("md_c%0d", i + 2));
    tick("md_after");

    // Memory wait with ack five cycles after the request.
    mem_req = 1'b1;
    tick("mw_req");
    for (int i = 0; i < 4; i++) tick($sformatf("mw_wait%0d", i));
    mem_ack = 1'b1;
    tick("mw_ack");
    idle_inputs();
    tick("mw_after");

    // Memory stall beats a simultaneous mul/div start and load-use hazard.
    mem_req = 1'b1; ex_muldiv_start = 1'b1;
    ex_is_load = 1'b1; ex_regwe = 1'b1; ex_rd = 5'd7; id_use_rs = 1'b1; id_rs = 5'd7;
    tick("pri_req");
    for (int i = 0; i < 2; i++) tick($sformatf("pri_wait%0d", i));
    mem_ack = 1'b1;
    tick("pri_ack");
    mem_req = 1'b0; mem_ack = 1'b0; ex_is_load = 1'b0;
    tick("pri_md_issue");
    ex_muldiv_start = 1'b0;
    for (int i = 0; i < LAT - 1; i++) tick($sformatf("pri_md%0d", i));
    idle_inputs();

    // Reset in the second mul/div cycle.
    ex_muldiv_start = 1'b1;
    tick("rmd_issue");
    ex_muldiv_start = 1'b0; rst = 1'b1;
    tick("rmd_rst");
    rst = 1'b0;
    tick("rmd_after");
    tick("rmd_after2");

    // Memory timeout: never acknowledged.
    mem_req = 1'b1;
    tick("to_req");
    mem_req = 1'b0;
    for (int i = 0; i < TO + 1; i++) tick($sformatf("to_w%0d", i));
    for (int i = 0; i < 3; i++) tick($sformatf("to_sticky%0d", i));
    ex_muldiv_start = 1'b1;
    tick("to_sticky_md");
    ex_muldiv_start = 1'b0;
    for (int i = 0; i < LAT; i++) tick($sformatf("to_sticky_md%0d", i));
    rst = 1'b1;
    tick("to_rst");
    rst = 1'b0;
    tick("to_cleared");

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 99) == 0);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      id_use_rs       = 1'($urandom_range(0, 1));
      id_use_rt       = 1'($urandom_range(0, 1));
      ex_regwe        = 1'($urandom_range(0, 1));
      ex_is_load      = 1'($urandom_range(0, 1));
      ex_muldiv_start = ($urandom_range(0, 4) == 0);
      mem_req         = ($urandom_range(0, 5) == 0);
      mem_ack         = ($urandom_range(0, 2) == 0);
      tick($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
